sample_demultiplexer: RTL and testbench

Receive-side counterpart of the sample multiplexer. Consumes an 8-bit byte stream under a ready/acknowledge handshake and reassembles 48-bit timetag samples, including the lost-sample flag in bit 47. A double-buffered output presents each sample under a ready/acknowledge handshake. Used for host-to-FPGA sample playback and for on-chip loopback verification of the sample path, all in the `clk` domain.

---
 rtl/sample_demultiplexer_pkg.sv | 18 +
 rtl/sample_demultiplexer_idle_timer.sv | 27 ++
 rtl/sample_demultiplexer.sv | 161 ++++++++++++++++
 tb/tb_sample_demultiplexer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_demultiplexer_pkg.sv
// rtl/sample_demultiplexer_pkg.sv - shared sample-path constants, demux states and helpers
package sample_demultiplexer_pkg;

    localparam int SAMPLE_WIDTH     = 48;
    localparam int BYTES_PER_SAMPLE = 6;
    localparam int SAMPLE_LOST_BIT  = 47;
    localparam int IDX_W            = 3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } demux_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sample_demultiplexer_idle_timer.sv
// rtl/sample_demultiplexer_idle_timer.sv - inter-byte idle counter with one-cycle expiry pulse
module sample_demultiplexer_idle_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] r_count;

    // A clear in the same cycle as the limit means a byte arrived in time.
    assign o_expired = i_enable && !i_clear && (r_count == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear || o_expired) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/sample_demultiplexer.sv
// rtl/sample_demultiplexer.sv - byte stream to 48-bit sample reassembly with double-buffered output
// Statistics counters are built only when DEMUX_STATS_EN is defined.
module sample_demultiplexer
    import sample_demultiplexer_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_rdy,
    input  logic [7:0]              data,
    output logic                    data_ack,
    output logic                    sample_rdy,
    output logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_ack,
    output logic                    frame_err,
    output logic [31:0]             samples_rx,
    output logic [15:0]             lost_rx,
    output logic [15:0]             frame_err_cnt
);

    localparam int              ASM_W    = SAMPLE_WIDTH - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);

    demux_state_t      r_state;
    demux_state_t      w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [ASM_W-1:0]  r_asm;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic              r_sample_rdy;
    logic              r_frame_err;

    logic w_last_byte;
    logic w_stall;
    logic w_xfer;
    logic w_load;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;

    // Only the final byte can be held off; earlier bytes go into the assembly register.
    assign w_last_byte = (r_idx == LAST_IDX);
    assign w_stall     = w_last_byte && r_sample_rdy && !sample_ack;
    assign w_xfer      = data_rdy && !w_stall && !reset;
    assign w_load      = w_xfer && w_last_byte;

    assign data_ack    = w_xfer;
    assign sample_rdy  = r_sample_rdy;
    assign sample      = r_sample;
    assign frame_err   = r_frame_err;

    assign w_timer_clear = w_xfer || (r_state == ST_IDLE);
    assign w_timer_en    = (r_state == ST_ASSEMBLE) && !w_stall;

    sample_demultiplexer_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_next = ST_ASSEMBLE;
                    w_idx_next   = IDX_W'(1);
                end
            end
            ST_ASSEMBLE: begin
                if (w_xfer) begin
                    if (w_last_byte) begin
                        w_state_next = ST_IDLE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_asm        <= '0;
            r_sample     <= '0;
            r_sample_rdy <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_expired;
            if (w_expired) begin
                r_asm <= '0;
            end else if (w_xfer && !w_last_byte) begin
                r_asm[{r_idx, 3'b000} +: 8] <= data;
            end
            // A load in the same cycle as an acknowledge keeps sample_rdy high.
            if (w_load) begin
                r_sample     <= {data, r_asm};
                r_sample_rdy <= 1'b1;
            end else if (sample_ack) begin
                r_sample_rdy <= 1'b0;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [31:0] r_samples_rx;
    logic [15:0] r_lost_rx;
    logic [15:0] r_frame_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samples_rx    <= '0;
            r_lost_rx       <= '0;
            r_frame_err_cnt <= '0;
        end else begin
            if (r_sample_rdy && sample_ack) begin
                r_samples_rx <= r_samples_rx + 32'd1;
                if (r_sample[SAMPLE_LOST_BIT]) begin
                    r_lost_rx <= sat_inc16(r_lost_rx);
                end
            end
            if (w_expired) begin
                r_frame_err_cnt <= sat_inc16(r_frame_err_cnt);
            end
        end
    end

    assign samples_rx    = r_samples_rx;
    assign lost_rx       = r_lost_rx;
    assign frame_err_cnt = r_frame_err_cnt;
`else
    assign samples_rx    = '0;
    assign lost_rx       = '0;
    assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_demultiplexer.sv
// tb/tb_sample_demultiplexer.sv - self-checking bench for sample_demultiplexer (DEMUX_STATS_EN optional)
module tb_sample_demultiplexer;

    localparam int TO = 8;
`ifdef DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_rdy = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        sample_ack = 1'b0;
    logic        data_ack;
    logic        sample_rdy;
    logic [47:0] sample;
    logic        frame_err;
    logic [31:0] samples_rx;
    logic [15:0] lost_rx;
    logic [15:0] frame_err_cnt;

    sample_demultiplexer #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_rdy      (data_rdy),
        .data          (data),
        .data_ack      (data_ack),
        .sample_rdy    (sample_rdy),
        .sample        (sample),
        .sample_ack    (sample_ack),
        .frame_err     (frame_err),
        .samples_rx    (samples_rx),
        .lost_rx       (lost_rx),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: bytes collected so far, pending output word, idle cycles since last byte.
    logic [7:0]  m_q[$];
    int          m_idle = 0;
    bit          m_rdy = 1'b0;
    logic [47:0] m_sample = '0;
    bit          m_ferr = 1'b0;
    logic [31:0] m_samples = '0;
    int          m_lost = 0;
    int          m_ferr_cnt = 0;

    function automatic bit m_stall();
        return (m_q.size() == 5) && m_rdy && !sample_ack;
    endfunction

    function automatic bit m_ack();
        return data_rdy && !reset && !m_stall();
    endfunction

    always @(posedge clk) begin : model
        bit xfer;
        bit hs;
        bit stall;
        if (reset) begin
            m_q.delete();
            m_idle = 0; m_rdy = 1'b0; m_sample = '0; m_ferr = 1'b0;
            m_samples = '0; m_lost = 0; m_ferr_cnt = 0;
        end else begin
            xfer  = m_ack();
            stall = m_stall();
            hs    = m_rdy && sample_ack;
            m_ferr = 1'b0;
            if (hs) begin
                m_samples = m_samples + 32'd1;
                if (m_sample[47] && m_lost < 65535) m_lost++;
                m_rdy = 1'b0;
            end
            if (xfer) begin
                m_q.push_back(data);
                m_idle = 0;
                if (m_q.size() == 6) begin
                    m_sample = '0;
                    for (int i = 0; i < 6; i++) m_sample = m_sample | (48'(m_q[i]) << (8 * i));
                    m_rdy = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() > 0 && !stall) begin
                if (m_idle == TO) begin
                    m_q.delete();
                    m_idle = 0;
                    m_ferr = 1'b1;
                    if (m_ferr_cnt < 65535) m_ferr_cnt++;
                end else begin
                    m_idle++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cmp_data_ack", 64'(data_ack), 64'(m_ack()));
            check("cmp_sample_rdy", 64'(sample_rdy), 64'(m_rdy));
            check("cmp_sample", 64'(sample), 64'(m_sample));
            check("cmp_frame_err", 64'(frame_err), 64'(m_ferr));
            check("cmp_samples_rx", 64'(samples_rx), STATS ? 64'(m_samples) : 64'd0);
            check("cmp_lost_rx", 64'(lost_rx), STATS ? 64'(m_lost) : 64'd0);
            check("cmp_frame_err_cnt", 64'(frame_err_cnt), STATS ? 64'(m_ferr_cnt) : 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        data_rdy = 1'b1;
        data = b;
        @(negedge clk);
        while (!data_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ack", 64'(data_ack), 64'd1);
        @(posedge clk); #1;
        data_rdy = 1'b0;
    endtask

    task automatic send_sample(input logic [47:0] s);
        for (int i = 0; i < 6; i++) send_byte(s[8*i +: 8]);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        int at;
        reset = 1'b1;
        @(posedge clk);
        armed = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_sample_rdy", 64'(sample_rdy), 64'd0);
        check("rst_sample", 64'(sample), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_samples_rx", 64'(samples_rx), 64'd0);
        step();

        // single sample, consumer always ready
        sample_ack = 1'b1;
        send_sample(48'hFEED_DEAD_BEEF);
        @(negedge clk);
        check("s1_rdy", 64'(sample_rdy), 64'd1);
        check("s1_sample", 64'(sample), 64'hFEEDDEADBEEF);
        @(negedge clk);
        check("s1_rdy_drop", 64'(sample_rdy), 64'd0);
        check("s1_samples_rx", 64'(samples_rx), STATS ? 64'd1 : 64'd0);
        check("s1_lost_rx", 64'(lost_rx), STATS ? 64'd1 : 64'd0);
        step();

        // back-pressure on the sixth byte only
        sample_ack = 1'b0;
        send_sample(48'h1615_1413_1211);
        for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i));
        data_rdy = 1'b1;
        data = 8'h26;
        @(negedge clk);
        check("bp_stall_ack", 64'(data_ack), 64'd0);
        check("bp_hold_sample", 64'(sample), 64'h161514131211);
        @(negedge clk);
        check("bp_stall_ack2", 64'(data_ack), 64'd0);
        step();
        sample_ack = 1'b1;
        @(negedge clk);
        check("bp_release_ack", 64'(data_ack), 64'd1);
        step();
        data_rdy = 1'b0;
        @(negedge clk);
        check("bp_rdy_kept", 64'(sample_rdy), 64'd1);
        check("bp_sample2", 64'(sample), 64'h262524232221);
        step();

        // timeout after three bytes
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        pulses = 0;
        at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (frame_err) begin
                pulses++;
                at = i;
            end
        end
        check("to_pulses", 64'(pulses), 64'd1);
        check("to_pulse_cycle", 64'(at), 64'd10);
        check("to_err_cnt", 64'(frame_err_cnt), STATS ? 64'd1 : 64'd0);
        step();
        send_sample(48'h0605_0403_0201);
        @(negedge clk);
        check("to_next_sample", 64'(sample), 64'h060504030201);
        step();

        // byte arriving on the expiring cycle wins
        send_byte(8'h31);
        repeat (8) @(posedge clk);
        #1;
        send_byte(8'h32);
        @(negedge clk);
        check("tie_no_err", 64'(frame_err), 64'd0);
        step();
        for (int i = 0; i < 4; i++) send_byte(8'h33 + 8'(i));
        @(negedge clk);
        check("tie_sample", 64'(sample), 64'h363534333231);
        check("tie_err_cnt", 64'(frame_err_cnt), STATS ? 64'd1 : 64'd0);
        step();

        // reset with a pending sample and a partial one
        sample_ack = 1'b0;
        send_sample(48'h7675_7473_7271);
        for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
        data_rdy = 1'b1;
        data = 8'h45;
        reset = 1'b1;
        @(negedge clk);
        check("rst_ack_forced", 64'(data_ack), 64'd0);
        step();
        reset = 1'b0;
        data_rdy = 1'b0;
        @(negedge clk);
        check("rm_sample_rdy", 64'(sample_rdy), 64'd0);
        check("rm_sample", 64'(sample), 64'd0);
        check("rm_samples_rx", 64'(samples_rx), 64'd0);
        check("rm_err_cnt", 64'(frame_err_cnt), 64'd0);
        step();
        sample_ack = 1'b1;
        send_sample(48'h5655_5453_5251);
        @(negedge clk);
        check("rm_next_sample", 64'(sample), 64'h565554535251);
        check("rm_next_rdy", 64'(sample_rdy), 64'd1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
